// File: rtl/forth_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the boot loader.
// The loader connects through the slave modport; the byte source and RAM side use master.
interface forth_loader_if #(
    parameter int iaddr_width = 10
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [iaddr_width-1:0] imem_addr;
    logic [15:0]            imem_wdata;
    logic                   imem_we;
    logic                   cpu_reset;
    logic                   done;
    logic                   error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_addr, imem_wdata, imem_we, cpu_reset, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_addr, imem_wdata, imem_we, cpu_reset, done, error
    );
endinterface

// File: rtl/forth_loader.sv
// Boot loader: parses SYNC/LEN/data/CSUM frames, writes 16-bit words to instruction RAM
// from address 0 and releases the core's reset once a frame with a good checksum lands.
module forth_loader #(
    parameter int          iaddr_width = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic           clk,
    input  logic           reset,
    forth_loader_if.slave  bus
);
    localparam int          CW    = iaddr_width + 1;
    localparam logic [16:0] MAX_N = 17'(1) << iaddr_width;

    typedef enum logic [2:0] {
        S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [CW-1:0]          len_q, len_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             hi_q, hi_d;
    logic [7:0]             sum_q, sum_d;
    logic [iaddr_width-1:0] addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   accept;
    logic [15:0]            n_full;
    logic [CW-1:0]          cnt_next;

    assign bus.rx_ready   = !reset && (state_q != S_RUN);
    assign accept         = bus.rx_valid && bus.rx_ready;
    assign n_full         = {len_hi_q, bus.rx_data};
    assign cnt_next       = cnt_q + 1'b1;

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.imem_we    = we_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        sum_d       = sum_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        if (accept) begin
            case (state_q)
                S_SYNC: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        error_d = 1'b0;
                        state_d = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    len_hi_d = bus.rx_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    // len_q only needs CW bits because oversize lengths never get past here
                    if (n_full == 16'd0 || {1'b0, n_full} > MAX_N) begin
                        error_d = 1'b1;
                        state_d = S_SYNC;
                    end else begin
                        len_d   = CW'(n_full);
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    sum_d   = sum_q + bus.rx_data;
                    addr_d  = cnt_q[iaddr_width-1:0];
                    wdata_d = {hi_q, bus.rx_data};
                    we_d    = 1'b1;
                    cnt_d   = cnt_next;
                    state_d = (cnt_next == len_q) ? S_CSUM : S_DATA_HI;
                end
                S_CSUM: begin
                    if (bus.rx_data == sum_q) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = S_RUN;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_SYNC;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SYNC;
            len_hi_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            sum_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            sum_q       <= sum_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_forth_loader.sv
// Directed bench for forth_loader: a table of whole frames plus hand-timed sequences
// for write latency, error edges, maximum length and reset mid-frame.
module tb_forth_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    forth_loader_if #(.iaddr_width(10)) bus ();

    forth_loader #(.iaddr_width(10), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // every write strobe seen on the RAM side, as {addr, data}
    logic [25:0] wq[$];
    always @(negedge clk) if (bus.imem_we) wq.push_back({bus.imem_addr, bus.imem_wdata});

    typedef struct {
        string          name;
        int             nb;
        logic [0:11][7:0] b;
        bit             gaps;
        int             nwr;
        logic [9:0]     la;
        logic [15:0]    ld;
        bit             edone;
        bit             eerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // returns #1 after the edge that consumed the byte
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            bus.rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_nominal();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hE0); send(8'h40); send(8'h66);
    endtask

    initial begin
        int base;
        logic [7:0] sum;
        logic [15:0] w;
        vec_t v;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // CSUM covers data bytes only: 12+34+E0+40 = 0x166 -> 66
        vecs[0] = '{"nominal",  8, 96'hA5_00_02_12_34_E0_40_66_00_00_00_00, 1'b0, 2, 10'd1, 16'hE040, 1'b1, 1'b0};
        vecs[1] = '{"badsum",   8, 96'hA5_00_02_12_34_E0_40_46_00_00_00_00, 1'b0, 2, 10'd1, 16'hE040, 1'b0, 1'b1};
        vecs[2] = '{"garbage", 11, 96'h00_FF_5A_A5_00_02_12_34_E0_40_66_00, 1'b1, 2, 10'd1, 16'hE040, 1'b1, 1'b0};
        vecs[3] = '{"len0",     3, 96'hA5_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 0, 10'd0, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{"len1025",  3, 96'hA5_04_01_00_00_00_00_00_00_00_00_00, 1'b0, 0, 10'd0, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{"oneword",  6, 96'hA5_00_01_AB_CD_78_00_00_00_00_00_00, 1'b0, 1, 10'd0, 16'hABCD, 1'b1, 1'b0};
        vecs[6] = '{"len1024p", 5, 96'hA5_04_00_01_02_00_00_00_00_00_00_00, 1'b0, 1, 10'd0, 16'h0102, 1'b0, 1'b0};
        vecs[7] = '{"syncdata", 6, 96'hA5_00_01_A5_A5_4A_00_00_00_00_00_00, 1'b1, 1, 10'd0, 16'hA5A5, 1'b1, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.addr",      32'(bus.imem_addr),  32'd0);
        chk("rst.wdata",     32'(bus.imem_wdata), 32'd0);
        chk("rst.we",        32'(bus.imem_we),    32'd0);
        chk("rst.cpu_reset", 32'(bus.cpu_reset),  32'd1);
        chk("rst.done",      32'(bus.done),       32'd0);
        chk("rst.error",     32'(bus.error),      32'd0);
        chk("rst.rx_ready",  32'(bus.rx_ready),   32'd0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            v = vecs[k];
            do_reset();
            base = wq.size();
            for (int i = 0; i < v.nb; i++) begin
                if (v.gaps) begin
                    bus.rx_data = 8'hA5;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                send(v.b[i]);
            end
            repeat (2) @(negedge clk);
            chk($sformatf("%s.nwr", v.name), 32'(wq.size() - base), 32'(v.nwr));
            if (v.nwr > 0 && wq.size() >= base + v.nwr) begin
                chk($sformatf("%s.first_addr", v.name), 32'(wq[base][25:16]), 32'd0);
                chk($sformatf("%s.last", v.name), 32'(wq[base + v.nwr - 1]), 32'({v.la, v.ld}));
            end
            chk($sformatf("%s.done", v.name),      32'(bus.done),      32'(v.edone));
            chk($sformatf("%s.error", v.name),     32'(bus.error),     32'(v.eerr));
            chk($sformatf("%s.cpu_reset", v.name), 32'(bus.cpu_reset), 32'(!v.edone));
            chk($sformatf("%s.rx_ready", v.name),  32'(bus.rx_ready),  32'(!v.edone));
        end

        // write latency and completion timing, then RUN ignores input, then reset in RUN
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        chk("t.we1",    32'(bus.imem_we),    32'd1);
        chk("t.addr1",  32'(bus.imem_addr),  32'd0);
        chk("t.data1",  32'(bus.imem_wdata), 32'h1234);
        send(8'hE0);
        chk("t.we_pulse", 32'(bus.imem_we),  32'd0);
        chk("t.hold",   32'(bus.imem_wdata), 32'h1234);
        send(8'h40);
        chk("t.addr2",  32'(bus.imem_addr),  32'd1);
        chk("t.done_early", 32'(bus.done),   32'd0);
        send(8'h66);
        chk("t.done",      32'(bus.done),      32'd1);
        chk("t.cpu_reset", 32'(bus.cpu_reset), 32'd0);
        chk("t.ready",     32'(bus.rx_ready),  32'd0);
        base = wq.size();
        bus.rx_data = 8'hA5;
        bus.rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("run.nowr",  32'(wq.size() - base), 32'd0);
        chk("run.done",  32'(bus.done), 32'd1);
        do_reset();
        chk("runrst.done",      32'(bus.done),      32'd0);
        chk("runrst.cpu_reset", 32'(bus.cpu_reset), 32'd1);

        // error rise/fall edges and recovery with a good frame
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hE0); send(8'h40); send(8'h47);
        chk("e.set",   32'(bus.error), 32'd1);
        chk("e.cpu",   32'(bus.cpu_reset), 32'd1);
        send(8'h5A);
        chk("e.garbage_keeps", 32'(bus.error), 32'd1);
        base = wq.size();
        send(8'hA5);
        chk("e.clear", 32'(bus.error), 32'd0);
        send(8'h00);
        chk("e.len_hi", 32'(bus.error), 32'd0);
        send(8'h00);
        chk("e.len0",  32'(bus.error), 32'd1);
        chk("e.nowr",  32'(wq.size() - base), 32'd0);
        send_nominal();
        chk("e.recover_done",  32'(bus.done),  32'd1);
        chk("e.recover_error", 32'(bus.error), 32'd0);

        // maximum length: word i = i, last write must land at 1023
        do_reset();
        base = wq.size();
        sum = 8'h00;
        send(8'hA5); send(8'h04); send(8'h00);
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i);
            send(w[15:8]);
            send(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
        end
        chk("max.pre_done", 32'(bus.done), 32'd0);
        send(sum);
        chk("max.done", 32'(bus.done), 32'd1);
        chk("max.nwr",  32'(wq.size() - base), 32'd1024);
        if (wq.size() >= base + 1024) begin
            chk("max.first", 32'(wq[base]),        32'({10'd0, 16'h0000}));
            chk("max.mid",   32'(wq[base + 512]),  32'({10'd512, 16'h0200}));
            chk("max.last",  32'(wq[base + 1023]), 32'({10'd1023, 16'h03FF}));
        end

        // reset mid-frame with a half word pending
        do_reset();
        base = wq.size();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mr.ready",     32'(bus.rx_ready),  32'd0);
        chk("mr.cpu_reset", 32'(bus.cpu_reset), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr.nwr", 32'(wq.size() - base), 32'd1);
        send_nominal();
        repeat (2) @(negedge clk);
        chk("mr.reload_nwr", 32'(wq.size() - base), 32'd3);
        if (wq.size() >= base + 3) begin
            chk("mr.w0", 32'(wq[base + 1]), 32'({10'd0, 16'h1234}));
            chk("mr.w1", 32'(wq[base + 2]), 32'({10'd1, 16'hE040}));
        end
        chk("mr.done", 32'(bus.done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
